// File: rtl/insn_fetch_bridge_pkg.sv
`default_nettype none
// insn_fetch_bridge_pkg -- shared fetch-queue defaults and entry type.
// Revision 1.0
package insn_fetch_bridge_pkg;

  localparam int FETCH_Q_DEPTH    = 4;
  localparam int FETCH_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-3:0] addr;
    logic                        kill;
  } fetch_q_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ptr_ring.sv
`default_nettype none
// fetch_ptr_ring -- head/send/tail pointers of the fetch queue plus occupancy compares.
// Revision 1.0
module fetch_ptr_ring
  import insn_fetch_bridge_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  localparam int IW   = $clog2(DEPTH),
  localparam int PW   = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enq,
  input  logic          i_issue,
  input  logic          i_retire,
  input  logic          i_flush,
  input  logic          i_redirect,
  output logic [IW-1:0] o_head_idx,
  output logic [IW-1:0] o_send_idx,
  output logic [IW-1:0] o_tail_idx,
  output logic [IW-1:0] o_send_next_idx,
  output logic [PW-1:0] o_kill_cnt,
  output logic          o_full,
  output logic          o_req_pending,
  output logic          o_inflight,
  output logic          o_redirect_room
);

  logic [PW-1:0] r_head, r_send, r_tail;
  logic [PW-1:0] w_send_next, w_occ;

  assign w_send_next     = r_send + PW'(i_issue);
  assign w_occ           = r_tail - r_head;
  assign o_full          = (w_occ == PW'(DEPTH));
  assign o_req_pending   = (r_send != r_tail);
  assign o_inflight      = (r_head != r_send);
  assign o_kill_cnt      = w_send_next - r_head;
  // A redirect slot exists unless every entry is already in flight after this cycle's issue.
  assign o_redirect_room = (o_kill_cnt != PW'(DEPTH));

  assign o_head_idx      = r_head[IW-1:0];
  assign o_send_idx      = r_send[IW-1:0];
  assign o_tail_idx      = r_tail[IW-1:0];
  assign o_send_next_idx = w_send_next[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_send <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + PW'(i_retire);
      r_send <= w_send_next;
      if (i_flush) r_tail <= w_send_next + PW'(i_redirect);
      else         r_tail <= r_tail + PW'(i_enq);
    end
  end

endmodule
`default_nettype wire

// File: rtl/insn_fetch_bridge.sv
`default_nettype none
// insn_fetch_bridge -- queues core fetches onto a ready/valid imem bus, returns tagged in-order responses.
// Revision 1.0
module insn_fetch_bridge
  import insn_fetch_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = FETCH_Q_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insn_fetch_en,
  input  logic [ADDR_WIDTH-3:0] insn_fetch_addr,
  input  logic                  flush,
  output logic                  insn_fetch_valid,
  output logic [INSN_WIDTH-1:0] insn_fetch_data,
  output logic [ADDR_WIDTH-3:0] insn_fetched_addr,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-3:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [INSN_WIDTH-1:0] mem_rsp_data,
  output logic                  overflow,
  output logic                  proto_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  fetch_q_entry_t        r_q [DEPTH];
  logic                  r_valid, r_overflow, r_proto_err;
  logic [INSN_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-3:0] r_addr;

  logic [IW-1:0]    w_head_idx, w_send_idx, w_tail_idx, w_send_next_idx, w_wr_idx;
  logic [PW-1:0]    w_kill_cnt;
  logic             w_full, w_req_pending, w_inflight, w_redirect_room;
  logic             w_issue, w_retire, w_stray, w_enq, w_redirect, w_drop, w_wr_en;
  logic [DEPTH-1:0] w_in_kill;

  fetch_ptr_ring #(.DEPTH(DEPTH)) u_ring (
    .clk             (clk),
    .rst             (rst),
    .i_enq           (w_enq),
    .i_issue         (w_issue),
    .i_retire        (w_retire),
    .i_flush         (flush),
    .i_redirect      (w_redirect),
    .o_head_idx      (w_head_idx),
    .o_send_idx      (w_send_idx),
    .o_tail_idx      (w_tail_idx),
    .o_send_next_idx (w_send_next_idx),
    .o_kill_cnt      (w_kill_cnt),
    .o_full          (w_full),
    .o_req_pending   (w_req_pending),
    .o_inflight      (w_inflight),
    .o_redirect_room (w_redirect_room)
  );

  assign mem_req_valid = w_req_pending;
  assign mem_req_addr  = r_q[w_send_idx].addr;

  assign w_issue    = w_req_pending & mem_req_ready;
  assign w_retire   = mem_rsp_valid & w_inflight;
  assign w_stray    = mem_rsp_valid & ~w_inflight;
  assign w_enq      = insn_fetch_en & ~flush & ~w_full;
  assign w_redirect = insn_fetch_en & flush & w_redirect_room;
  assign w_drop     = insn_fetch_en & (flush ? ~w_redirect_room : w_full);
  assign w_wr_en    = w_enq | w_redirect;
  assign w_wr_idx   = flush ? w_send_next_idx : w_tail_idx;

  // Entry is killed when its distance from head falls inside [head, send_next).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
    logic [IW-1:0] w_off;
    assign w_off         = IW'(gi) - w_head_idx;
    assign w_in_kill[gi] = ({1'b0, w_off} < w_kill_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && w_in_kill[i]) r_q[i].kill <= 1'b1;
      end
      if (w_wr_en) r_q[w_wr_idx] <= '{addr: insn_fetch_addr, kill: 1'b0};

      r_valid <= w_retire & ~r_q[w_head_idx].kill;
      if (w_retire) begin
        r_data <= mem_rsp_data;
        r_addr <= r_q[w_head_idx].addr;
      end
      if (w_drop)  r_overflow  <= 1'b1;
      if (w_stray) r_proto_err <= 1'b1;
    end
  end

  assign insn_fetch_valid  = r_valid;
  assign insn_fetch_data   = r_data;
  assign insn_fetched_addr = r_addr;
  assign overflow          = r_overflow;
  assign proto_err         = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch_bridge.sv
`default_nettype none
// tb_insn_fetch_bridge -- scoreboard bench with a queue-level reference model of the fetch bridge.
// Revision 1.0
module tb_insn_fetch_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int WA = AW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, flush, rq_r, rs_v;
  logic [WA-1:0] faddr;
  logic [DW-1:0] rs_d;
  logic          fv, rq_v, ovf, perr;
  logic [DW-1:0] fdata;
  logic [WA-1:0] fadr, rq_a;

  insn_fetch_bridge #(.ADDR_WIDTH(AW), .INSN_WIDTH(DW), .DEPTH(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .insn_fetch_en     (en),
    .insn_fetch_addr   (faddr),
    .flush             (flush),
    .insn_fetch_valid  (fv),
    .insn_fetch_data   (fdata),
    .insn_fetched_addr (fadr),
    .mem_req_valid     (rq_v),
    .mem_req_addr      (rq_a),
    .mem_req_ready     (rq_r),
    .mem_rsp_valid     (rs_v),
    .mem_rsp_data      (rs_d),
    .overflow          (ovf),
    .proto_err         (perr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: entries already sent to memory, and entries waiting to be sent.
  typedef struct {logic [WA-1:0] addr; bit kill;} ment_t;
  typedef struct {logic [WA-1:0] addr; logic [DW-1:0] data; int due;} exp_t;
  ment_t         m_sent[$];
  logic [WA-1:0] m_unsent[$];
  bit            m_ovf, m_perr;
  exp_t          sb[$];
  logic [WA-1:0] mem_q[$];
  logic [WA-1:0] issued[$];
  logic [WA-1:0] delivered[$];
  bit            mem_rand = 1'b0;
  bit            mem_hold = 1'b0;
  int            last_valid_cyc = -1;

  function automatic logic [DW-1:0] mem_word(input logic [WA-1:0] a);
    if (a == 30'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C0F96;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (fv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual_addr=%0h required=none", fadr);
        end else begin
          e = sb.pop_front();
          check("rsp_addr", 64'(fadr), 64'(e.addr));
          check("rsp_data", 64'(fdata), 64'(e.data));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
        delivered.push_back(fadr);
        last_valid_cyc = cyc;
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing actual=none required_addr=%0h due=%0d", e.addr, e.due);
      end
    end
  end

  task automatic model_step();
    bit    exp_rv, fire;
    int    infl, occ;
    ment_t h;
    exp_rv = (m_unsent.size() > 0);
    check("req_valid", 64'(rq_v), 64'(exp_rv));
    if (exp_rv) check("req_addr", 64'(rq_a), 64'(m_unsent[0]));
    check("overflow", 64'(ovf), 64'(m_ovf));
    check("proto_err", 64'(perr), 64'(m_perr));
    fire = exp_rv && rq_r;
    infl = m_sent.size();
    occ  = m_sent.size() + m_unsent.size();
    if (rs_v) begin
      if (mem_q.size() > 0) void'(mem_q.pop_front());
      if (m_sent.size() == 0) m_perr = 1'b1;
      else begin
        h = m_sent.pop_front();
        if (!h.kill) sb.push_back('{h.addr, mem_word(h.addr), cyc + 1});
      end
    end
    if (rq_v && rq_r) begin
      mem_q.push_back(rq_a);
      issued.push_back(rq_a);
    end
    if (fire) m_sent.push_back('{m_unsent.pop_front(), 1'b0});
    if (flush) begin
      foreach (m_sent[i]) m_sent[i].kill = 1'b1;
      m_unsent.delete();
      if (en) begin
        if (infl + int'(fire) == D) m_ovf = 1'b1;
        else m_unsent.push_back(faddr);
      end
    end else if (en) begin
      if (occ == D) m_ovf = 1'b1;
      else m_unsent.push_back(faddr);
    end
  endtask

  task automatic tick(input bit t_en, input logic [WA-1:0] t_addr, input bit t_flush,
                      input bit t_ready, input bit t_force_rsp);
    en    = t_en;
    faddr = t_addr;
    flush = t_flush;
    rq_r  = t_ready;
    rs_v  = 1'b0;
    rs_d  = '0;
    if (!mem_hold && mem_q.size() > 0 && (!mem_rand || $urandom_range(0, 99) < 60)) begin
      rs_v = 1'b1;
      rs_d = mem_word(mem_q[0]);
    end else if (t_force_rsp) begin
      rs_v = 1'b1;
      rs_d = 32'h12345678;
    end
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 64'(fv), 64'd0);
    check({tag, "_data"}, 64'(fdata), 64'd0);
    check({tag, "_faddr"}, 64'(fadr), 64'd0);
    check({tag, "_req_valid"}, 64'(rq_v), 64'd0);
    check({tag, "_overflow"}, 64'(ovf), 64'd0);
    check({tag, "_proto_err"}, 64'(perr), 64'd0);
  endtask

  task automatic model_clear();
    m_sent.delete();
    m_unsent.delete();
    sb.delete();
    mem_q.delete();
    delivered.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cyc, n22;
    rst = 1'b1; en = 1'b0; faddr = '0; flush = 1'b0; rq_r = 1'b0; rs_v = 1'b0; rs_d = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Single fetch, 1-cycle memory.
    req_cyc = cyc;
    tick(1, 30'h100, 0, 1, 0);
    repeat (5) tick(0, '0, 0, 1, 0);
    check("t1_latency", 64'(last_valid_cyc - req_cyc), 64'd3);
    check("t1_count", 64'(delivered.size()), 64'd1);
    if (delivered.size() > 0) check("t1_addr", 64'(delivered[0]), 64'h100);

    // Backpressure for 10 cycles overflows the queue.
    delivered.delete();
    for (int i = 0; i < 10; i++) tick(1, WA'(32'h10 + i), 0, 0, 0);
    check("t2_overflow", 64'(ovf), 64'd1);
    repeat (10) tick(0, '0, 0, 1, 0);
    check("t2_count", 64'(delivered.size()), 64'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      check("t2_order", 64'(delivered[i]), 64'(32'h10 + i));

    // Flush with two in flight and one unsent, redirect to 0x40.
    delivered.delete();
    issued.delete();
    mem_hold = 1'b1;
    tick(1, 30'h20, 0, 0, 0);
    tick(1, 30'h21, 0, 1, 0);
    tick(1, 30'h22, 0, 1, 0);
    tick(1, 30'h40, 1, 0, 0);
    mem_hold = 1'b0;
    repeat (10) tick(0, '0, 0, 1, 0);
    n22 = 0;
    foreach (issued[i]) if (issued[i] == 30'h22) n22++;
    check("t3_unsent_issued", 64'(n22), 64'd0);
    check("t3_count", 64'(delivered.size()), 64'd1);
    if (delivered.size() > 0) check("t3_addr", 64'(delivered[0]), 64'h40);

    // Stray response with nothing in flight.
    delivered.delete();
    tick(0, '0, 0, 1, 1);
    check("t4_proto_err", 64'(perr), 64'd1);
    repeat (4) tick(0, '0, 0, 1, 0);
    check("t4_no_valid", 64'(delivered.size()), 64'd0);
    check("t4_sticky", 64'(perr), 64'd1);

    // Async reset with three fetches in flight.
    mem_hold = 1'b1;
    tick(1, 30'h60, 0, 1, 0);
    tick(1, 30'h61, 0, 1, 0);
    tick(1, 30'h62, 0, 1, 0);
    tick(0, '0, 0, 1, 0);
    en = 1'b0; flush = 1'b0; rs_v = 1'b0;
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    model_clear();
    mem_hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1, 30'h80, 0, 1, 0);
    repeat (6) tick(0, '0, 0, 1, 0);
    check("t5_count", 64'(delivered.size()), 64'd1);
    if (delivered.size() > 0) check("t5_addr", 64'(delivered[0]), 64'h80);
    check("t5_proto_err", 64'(perr), 64'd0);

    // Randomized traffic with flushes, backpressure and variable memory latency.
    mem_rand = 1'b1;
    for (int i = 0; i < 2000; i++)
      tick($urandom_range(0, 2) != 0, WA'($urandom()), $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, 0);
    repeat (30) tick(0, '0, 0, 1, 0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
